instr_encode: RTL and testbench
===============================

INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have ports: in_valid input 1 request valid; in_ready output 1 request accepted when both high.
REQ-004 SHALL have ports: op input 5 operation code; rs, rt, rd, shift input 5 each register/shamt fields; imm input 16 immediate/branch offset; targ_addr input 26 jump target.
REQ-005 SHALL have ports: out_valid output 1, out_ready input 1, instr output 32 encoded word, addr output 10 word address of instr.
REQ-006 SHALL have ports: base_load input 1, base_addr input 10 address reload; err output 1 sticky illegal-op flag; err_clr input 1; stopped output 1; resume input 1; count output 11 words emitted.

Function
REQ-007 SHALL map op codes 0..26 in this order: ADD SUB SLT SLTU AND OR NOR XOR SLL SRL SRA SLLV SRLV SRAV ADDI ANDI ORI XORI SLTI SLTIU LW SW BEQ BNE BLEZ BGTZ J; 31 = HALT; 27..30 illegal.
REQ-008 SHALL encode R-type as opcode 000000, rs, rt, rd, shamt, funct: ADD 100000, SUB 100010, SLT 101010, SLTU 101011, AND 100100, OR 100101, NOR 100111, XOR 100110, SLL/SLLV 000000, SRL/SRLV 000010, SRA/SRAV 000011.
REQ-009 SHALL place shift in shamt for SLL/SRL/SRA and force shamt=0 for SLLV/SRLV/SRAV and all other R-type ops.
REQ-010 SHALL treat SLL/SRL/SRA with shift=0 as illegal (indistinguishable from variable form in our decoder).
REQ-011 SHALL encode I-type as opcode, rs, rt, imm: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, SLTIU 001011, LW 100011, SW 101011, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111; BLEZ/BGTZ force rt=0.
REQ-012 SHALL encode J as opcode 000010 with targ_addr in bits 25:0.
REQ-013 SHALL implement FSM EMPTY, FULL, STOPPED; reset state EMPTY.
REQ-014 in_ready SHALL be 1 in EMPTY, equal out_ready in FULL, 0 in STOPPED.
REQ-015 Legal op accepted in cycle N SHALL appear registered on instr with out_valid=1 in cycle N+1 (state FULL); full throughput with out_ready held high.
REQ-016 instr/addr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 On output handshake with no new acceptance, FSM SHALL go FULL->EMPTY.
REQ-018 Illegal op SHALL be accepted, not emitted, set err next cycle; FSM goes EMPTY if no word pending, else stays FULL until drain.
REQ-019 HALT SHALL be accepted, emit nothing; FSM goes STOPPED once no word pending (pending word drains first; in_ready=0 meanwhile).
REQ-020 STOPPED->EMPTY SHALL occur on resume; stopped=1 only in STOPPED.
REQ-021 addr SHALL increment by 1 per output handshake, wrapping 1023->0; count SHALL increment per handshake, saturating at 2047.
REQ-022 base_load SHALL set the next-address counter to base_addr; on same cycle as a handshake, the fired word keeps old addr and following word uses base_addr.
REQ-023 err_clr SHALL clear err; simultaneous illegal acceptance and err_clr SHALL leave err=1.

Reset
REQ-024 rst SHALL asynchronously force: state EMPTY, out_valid 0, instr 0, addr 0, count 0, err 0, stopped 0; pending word discarded.
REQ-025 After rst deasserts, in_ready SHALL be 1 on the first clock.

Structure
REQ-026 Op codes, opcode and funct constants, and FSM state encoding SHALL live in shared package mips_isa_pkg, also usable by decode.
REQ-027 Combinational field packing SHALL be sub-module instr_pack (op + fields -> 32-bit word + illegal flag); instr_encode holds FSM, output register, counters.

Verification
REQ-028 ADD rs=1 rt=2 rd=3, out_ready=1 -> instr=0x00221820, addr=0 one cycle later.
REQ-029 ADDI rs=0 rt=5 imm=0xFFFF, then J targ=0x10 back-to-back -> 0x2005FFFF at addr 0, 0x08000010 at addr 1, consecutive cycles.
REQ-030 SLLV rs=3 rt=2 rd=4 shift=7 -> 0x00622000; SLL shift=0 -> no output, err=1; err_clr -> err=0.
REQ-031 out_ready=0 for 3 cycles with word pending -> instr/addr stable, in_ready=0; then out_ready=1 -> single handshake, count=1.
REQ-032 base_load base_addr=1023, two words -> addr 1023 then 0 (wrap).
REQ-033 HALT while word pending -> word drains, stopped=1, in_ready=0; resume -> EMPTY, in_ready=1; rst mid-FULL -> out_valid=0 immediately.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS-subset ISA constants: op codes, major opcodes, funct codes and encoder FSM states.
// Used by the encoder and intended to be shared with decode logic.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        OpAdd   = 5'd0,
        OpSub, OpSlt, OpSltu, OpAnd, OpOr, OpNor, OpXor,
        OpSll, OpSrl, OpSra, OpSllv, OpSrlv, OpSrav,
        OpAddi, OpAndi, OpOri, OpXori, OpSlti, OpSltiu,
        OpLw, OpSw, OpBeq, OpBne, OpBlez, OpBgtz,
        OpJ,
        OpHalt  = 5'd31
    } op_e;

    localparam logic [5:0] OpcSpecial = 6'b000000;
    localparam logic [5:0] OpcJ       = 6'b000010;
    localparam logic [5:0] OpcBeq     = 6'b000100;
    localparam logic [5:0] OpcBne     = 6'b000101;
    localparam logic [5:0] OpcBlez    = 6'b000110;
    localparam logic [5:0] OpcBgtz    = 6'b000111;
    localparam logic [5:0] OpcAddi    = 6'b001000;
    localparam logic [5:0] OpcSlti    = 6'b001010;
    localparam logic [5:0] OpcSltiu   = 6'b001011;
    localparam logic [5:0] OpcAndi    = 6'b001100;
    localparam logic [5:0] OpcOri     = 6'b001101;
    localparam logic [5:0] OpcXori    = 6'b001110;
    localparam logic [5:0] OpcLw      = 6'b100011;
    localparam logic [5:0] OpcSw      = 6'b101011;

    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnNor  = 6'b100111;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnSltu = 6'b101011;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StFull    = 2'd1,
        StStopped = 2'd2
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: op code plus operand fields to a 32-bit MIPS word,
// with flags for illegal ops and HALT.
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shift_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] targ_addr_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        halt_o
);

    logic       is_r, is_i, is_j;
    logic [5:0] funct, opcode;
    logic [4:0] shamt, rt_eff;

    always_comb begin
        is_r      = 1'b0;
        is_i      = 1'b0;
        is_j      = 1'b0;
        funct     = 6'd0;
        opcode    = 6'd0;
        shamt     = 5'd0;
        rt_eff    = rt_i;
        illegal_o = 1'b0;
        halt_o    = 1'b0;
        case (op_i)
            OpAdd:  begin is_r = 1'b1; funct = FnAdd;  end
            OpSub:  begin is_r = 1'b1; funct = FnSub;  end
            OpSlt:  begin is_r = 1'b1; funct = FnSlt;  end
            OpSltu: begin is_r = 1'b1; funct = FnSltu; end
            OpAnd:  begin is_r = 1'b1; funct = FnAnd;  end
            OpOr:   begin is_r = 1'b1; funct = FnOr;   end
            OpNor:  begin is_r = 1'b1; funct = FnNor;  end
            OpXor:  begin is_r = 1'b1; funct = FnXor;  end
            // Constant shifts by zero would encode identically to the variable forms.
            OpSll:  begin is_r = 1'b1; funct = FnSll; shamt = shift_i;
                          illegal_o = (shift_i == 5'd0); end
            OpSrl:  begin is_r = 1'b1; funct = FnSrl; shamt = shift_i;
                          illegal_o = (shift_i == 5'd0); end
            OpSra:  begin is_r = 1'b1; funct = FnSra; shamt = shift_i;
                          illegal_o = (shift_i == 5'd0); end
            OpSllv: begin is_r = 1'b1; funct = FnSll;  end
            OpSrlv: begin is_r = 1'b1; funct = FnSrl;  end
            OpSrav: begin is_r = 1'b1; funct = FnSra;  end
            OpAddi:  begin is_i = 1'b1; opcode = OpcAddi;  end
            OpAndi:  begin is_i = 1'b1; opcode = OpcAndi;  end
            OpOri:   begin is_i = 1'b1; opcode = OpcOri;   end
            OpXori:  begin is_i = 1'b1; opcode = OpcXori;  end
            OpSlti:  begin is_i = 1'b1; opcode = OpcSlti;  end
            OpSltiu: begin is_i = 1'b1; opcode = OpcSltiu; end
            OpLw:    begin is_i = 1'b1; opcode = OpcLw;    end
            OpSw:    begin is_i = 1'b1; opcode = OpcSw;    end
            OpBeq:   begin is_i = 1'b1; opcode = OpcBeq;   end
            OpBne:   begin is_i = 1'b1; opcode = OpcBne;   end
            OpBlez:  begin is_i = 1'b1; opcode = OpcBlez; rt_eff = 5'd0; end
            OpBgtz:  begin is_i = 1'b1; opcode = OpcBgtz; rt_eff = 5'd0; end
            OpJ:     is_j = 1'b1;
            OpHalt:  halt_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        word_o = 32'd0;
        if (!illegal_o) begin
            if (is_r) begin
                word_o = {OpcSpecial, rs_i, rt_i, rd_i, shamt, funct};
            end else if (is_i) begin
                word_o = {opcode, rs_i, rt_eff, imm_i};
            end else if (is_j) begin
                word_o = {OpcJ, targ_addr_i};
            end
        end
    end

endmodule

// File: rtl/instr_encode.sv
// Instruction encoder: valid/ready front end, one-word output register, address and
// emitted-word counters, sticky illegal-op flag and HALT/resume control.
module instr_encode
    import mips_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shift,
    input  logic [15:0] imm,
    input  logic [25:0] targ_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [9:0]  addr,
    input  logic        base_load,
    input  logic [9:0]  base_addr,
    output logic        err,
    input  logic        err_clr,
    output logic        stopped,
    input  logic        resume,
    output logic [10:0] count
);

    state_e      state_q;
    logic        out_valid_q, err_q, stopped_q;
    logic [31:0] instr_q;
    logic [9:0]  addr_q, nxt_q;
    logic [10:0] count_q;

    logic [31:0] pack_word;
    logic        pack_illegal, pack_halt;
    logic        hs, acc, load;
    logic [9:0]  nxt_base;

    instr_pack u_pack (
        .op_i        (op),
        .rs_i        (rs),
        .rt_i        (rt),
        .rd_i        (rd),
        .shift_i     (shift),
        .imm_i       (imm),
        .targ_addr_i (targ_addr),
        .word_o      (pack_word),
        .illegal_o   (pack_illegal),
        .halt_o      (pack_halt)
    );

    // Acceptance in FULL implies the pending word fires in the same cycle.
    assign in_ready = (state_q == StEmpty) || ((state_q == StFull) && out_ready);
    assign hs       = out_valid_q && out_ready;
    assign acc      = in_valid && in_ready;
    assign load     = acc && !pack_illegal && !pack_halt;
    assign nxt_base = base_load ? base_addr : nxt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            addr_q      <= 10'd0;
            nxt_q       <= 10'd0;
            count_q     <= 11'd0;
            err_q       <= 1'b0;
            stopped_q   <= 1'b0;
        end else begin
            if (acc && pack_illegal) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            if (hs && (count_q != 11'd2047)) begin
                count_q <= count_q + 11'd1;
            end

            if (load) begin
                instr_q <= pack_word;
                addr_q  <= nxt_base;
                nxt_q   <= nxt_base + 10'd1;
            end else if (base_load) begin
                nxt_q <= base_addr;
            end

            case (state_q)
                StEmpty: begin
                    if (load) begin
                        state_q     <= StFull;
                        out_valid_q <= 1'b1;
                    end else if (acc && pack_halt) begin
                        state_q   <= StStopped;
                        stopped_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (acc) begin
                        if (pack_halt) begin
                            state_q     <= StStopped;
                            out_valid_q <= 1'b0;
                            stopped_q   <= 1'b1;
                        end else if (pack_illegal) begin
                            state_q     <= StEmpty;
                            out_valid_q <= 1'b0;
                        end
                    end else if (hs) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StStopped: begin
                    if (resume) begin
                        state_q   <= StEmpty;
                        stopped_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    out_valid_q <= 1'b0;
                    stopped_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign addr      = addr_q;
    assign count     = count_q;
    assign err       = err_q;
    assign stopped   = stopped_q;

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode: encoding table plus handshake, addressing, error and HALT sequences.
module tb_instr_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  op, rs, rt, rd, shift;
    logic [15:0] imm;
    logic [25:0] targ_addr;
    logic        out_valid, out_ready;
    logic [31:0] instr;
    logic [9:0]  addr, base_addr;
    logic        base_load, err, err_clr, stopped, resume;
    logic [10:0] count;

    always #5 clk = ~clk;

    instr_encode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shift     (shift),
        .imm       (imm),
        .targ_addr (targ_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .addr      (addr),
        .base_load (base_load),
        .base_addr (base_addr),
        .err       (err),
        .err_clr   (err_clr),
        .stopped   (stopped),
        .resume    (resume),
        .count     (count)
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] targ;
        logic        exp_v;
        logic        exp_e;
        logic [31:0] exp_i;
    } vec_t;

    vec_t vecs[23];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int o, input int s, input int t, input int d, input int h,
                                input logic [15:0] im, input logic [25:0] tg, input logic v,
                                input logic e, input logic [31:0] w);
        vec_t r;
        r.op = 5'(o); r.rs = 5'(s); r.rt = 5'(t); r.rd = 5'(d); r.sh = 5'(h);
        r.imm = im; r.targ = tg; r.exp_v = v; r.exp_e = e; r.exp_i = w;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; op = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shift = 5'd0;
        imm = 16'd0; targ_addr = 26'd0; out_ready = 1'b1; base_load = 1'b0;
        base_addr = 10'd0; err_clr = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input int o, input int s, input int t, input int d, input int h,
                         input logic [15:0] im, input logic [25:0] tg);
        in_valid = 1'b1; op = 5'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d); shift = 5'(h);
        imm = im; targ_addr = tg;
    endtask

    initial begin
        int   exp_addr;
        int   n_legal;

        vecs[0]  = mk( 0,  1,  2,  3,  0, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h00221820);
        vecs[1]  = mk( 1,  4,  5,  6,  9, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h00853022);
        vecs[2]  = mk( 6, 31, 31, 31,  0, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h03FFF827);
        vecs[3]  = mk( 5,  1,  0,  2,  0, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h00201025);
        vecs[4]  = mk( 8,  0,  2,  4,  7, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h000221C0);
        vecs[5]  = mk(10,  0,  3,  1, 31, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h00030FC3);
        vecs[6]  = mk(11,  3,  2,  4,  7, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h00622000);
        vecs[7]  = mk(13,  1,  2,  3,  5, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h00221803);
        vecs[8]  = mk( 8,  0,  2,  4,  0, 16'h0000, 26'h0, 1'b0, 1'b1, 32'h0);
        vecs[9]  = mk( 9,  0,  2,  4,  0, 16'h0000, 26'h0, 1'b0, 1'b1, 32'h0);
        vecs[10] = mk(14,  0,  5,  0,  0, 16'hFFFF, 26'h0, 1'b1, 1'b0, 32'h2005FFFF);
        vecs[11] = mk(17,  7,  7,  0,  0, 16'hA5A5, 26'h0, 1'b1, 1'b0, 32'h38E7A5A5);
        vecs[12] = mk(19,  2,  3,  0,  0, 16'h0001, 26'h0, 1'b1, 1'b0, 32'h2C430001);
        vecs[13] = mk(20, 29,  8,  0,  0, 16'h0010, 26'h0, 1'b1, 1'b0, 32'h8FA80010);
        vecs[14] = mk(21, 29, 31,  0,  0, 16'hFFFC, 26'h0, 1'b1, 1'b0, 32'hAFBFFFFC);
        vecs[15] = mk(23,  1,  2,  0,  0, 16'h1234, 26'h0, 1'b1, 1'b0, 32'h14221234);
        vecs[16] = mk(24,  1,  7,  0,  0, 16'h8000, 26'h0, 1'b1, 1'b0, 32'h18208000);
        vecs[17] = mk(25,  4,  9,  0,  0, 16'h0003, 26'h0, 1'b1, 1'b0, 32'h1C800003);
        vecs[18] = mk(27,  1,  2,  3,  4, 16'h0000, 26'h0, 1'b0, 1'b1, 32'h0);
        vecs[19] = mk(26,  0,  0,  0,  0, 16'h0000, 26'h10, 1'b1, 1'b0, 32'h08000010);
        vecs[20] = mk(30,  0,  0,  0,  0, 16'h0000, 26'h0, 1'b0, 1'b1, 32'h0);
        vecs[21] = mk(26,  5,  5,  5,  5, 16'hFFFF, 26'h3FFFFFF, 1'b1, 1'b0, 32'h0BFFFFFF);
        vecs[22] = mk( 9,  0, 31, 31,  1, 16'h0000, 26'h0, 1'b1, 1'b0, 32'h001FF842);

        // Reset state
        idle_inputs();
        rst = 1'b1;
        do_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stopped", 32'(stopped), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Encoding table
        exp_addr = 0;
        n_legal  = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            err_clr = 1'b0;
            drive(int'(vecs[i].op), int'(vecs[i].rs), int'(vecs[i].rt), int'(vecs[i].rd),
                  int'(vecs[i].sh), vecs[i].imm, vecs[i].targ);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                chk($sformatf("v%0d_instr", i), instr, vecs[i].exp_i);
                chk($sformatf("v%0d_addr", i), 32'(addr), 32'(exp_addr));
                exp_addr++;
                n_legal++;
            end
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_e));
            err_clr = 1'b1;
        end
        @(negedge clk);
        err_clr = 1'b0;
        chk("tbl_count", 32'(count), 32'(n_legal));
        chk("tbl_drained", 32'(out_valid), 32'd0);

        // Back-to-back ADDI then J
        do_reset();
        @(negedge clk);
        drive(14, 0, 5, 0, 0, 16'hFFFF, 26'h0);
        @(negedge clk);
        chk("b2b_instr0", instr, 32'h2005FFFF);
        chk("b2b_addr0", 32'(addr), 32'd0);
        drive(26, 0, 0, 0, 0, 16'h0, 26'h10);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_valid1", 32'(out_valid), 32'd1);
        chk("b2b_instr1", instr, 32'h08000010);
        chk("b2b_addr1", 32'(addr), 32'd1);
        chk("b2b_count1", 32'(count), 32'd1);
        @(negedge clk);
        chk("b2b_valid_end", 32'(out_valid), 32'd0);
        chk("b2b_count2", 32'(count), 32'd2);

        // Output stall keeps word stable and blocks input
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        drive(0, 1, 2, 3, 0, 16'h0, 26'h0);
        @(negedge clk);
        drive(1, 4, 5, 6, 0, 16'h0, 26'h0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_instr", c), instr, 32'h00221820);
            chk($sformatf("stall%0d_addr", c), 32'(addr), 32'd0);
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_drain_valid", 32'(out_valid), 32'd0);
        chk("stall_count", 32'(count), 32'd1);

        // Base load with wrap, then reload coinciding with a handshake
        do_reset();
        @(negedge clk);
        base_load = 1'b1;
        base_addr = 10'd1023;
        @(negedge clk);
        base_load = 1'b0;
        drive(5, 1, 0, 2, 0, 16'h0, 26'h0);
        @(negedge clk);
        chk("base_addr1023", 32'(addr), 32'd1023);
        chk("base_instr0", instr, 32'h00201025);
        drive(20, 29, 8, 0, 0, 16'h0010, 26'h0);
        @(negedge clk);
        chk("base_addr_wrap", 32'(addr), 32'd0);
        chk("base_instr1", instr, 32'h8FA80010);
        drive(23, 1, 2, 0, 0, 16'h1234, 26'h0);
        base_load = 1'b1;
        base_addr = 10'd5;
        @(negedge clk);
        base_load = 1'b0;
        in_valid  = 1'b0;
        chk("base_reload_addr", 32'(addr), 32'd5);
        chk("base_instr2", instr, 32'h14221234);
        @(negedge clk);
        chk("base_count", 32'(count), 32'd3);

        // Sticky error: set wins over a simultaneous clear
        do_reset();
        @(negedge clk);
        drive(27, 0, 0, 0, 0, 16'h0, 26'h0);
        @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        drive(28, 0, 0, 0, 0, 16'h0, 26'h0);
        err_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_set_over_clr", 32'(err), 32'd1);
        chk("err_no_output", 32'(out_valid), 32'd0);
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // HALT behind a pending word, then resume
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        drive(0, 1, 2, 3, 0, 16'h0, 26'h0);
        @(negedge clk);
        drive(31, 0, 0, 0, 0, 16'h0, 26'h0);
        @(negedge clk);
        chk("halt_pend_valid", 32'(out_valid), 32'd1);
        chk("halt_pend_stopped", 32'(stopped), 32'd0);
        chk("halt_pend_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        drive(0, 1, 2, 3, 0, 16'h0, 26'h0);
        chk("halt_drained", 32'(out_valid), 32'd0);
        chk("halt_stopped", 32'(stopped), 32'd1);
        chk("halt_in_ready", 32'(in_ready), 32'd0);
        chk("halt_count", 32'(count), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("halt_blocks_input", 32'(out_valid), 32'd0);
        chk("halt_still_stopped", 32'(stopped), 32'd1);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_stopped", 32'(stopped), 32'd0);
        chk("resume_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset while a word is pending
        @(negedge clk);
        drive(0, 1, 2, 3, 0, 16'h0, 26'h0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("arst_discarded", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
